// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: datapath width, load funct3 codes,
// the buffered load entry and the load byte/halfword extension helper.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    logic [1:0]       addr_lo;
    logic [XLEN-1:0]  rdata;
  } ld_entry_t;

  // Select byte/halfword by address and extend; unknown encodings behave as LW.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_extend = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  load_extend = {{(XLEN-8){1'b0}}, b};
      F3_LH:   load_extend = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  load_extend = {{(XLEN-16){1'b0}}, h};
      default: load_extend = rdata;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load result buffer: DEPTH-entry circular FIFO with occupancy count.
// The head entry is presented combinationally while the FIFO is non-empty.
module wb_load_fifo
  import rv_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  ld_entry_t        din,
  input  logic             pop,
  output ld_entry_t        dout_c,
  output logic [CNT_W-1:0] count,
  output logic             empty_c
);

  ld_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             push_ok_c;
  logic             pop_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c    = (count == CNT_W'(DEPTH));
  assign empty_c   = (count == '0);
  assign push_ok_c = push && !full_c;
  assign pop_ok_c  = pop && !empty_c;
  assign dout_c    = mem[rd_ptr];

  // Payload storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok_c)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: arbitrates ALU and buffered load results onto the
// register file write port and keeps the pending-write scoreboard.
module wb_writeback_unit
  import rv_pkg::*;
#(
  parameter int unsigned LD_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [REG_W-1:0] ld_rd,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_addr_lo,
  input  logic [XLEN-1:0]  ld_rdata,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREGS-1:0] pending
);

  localparam int unsigned CNT_W = $clog2(LD_DEPTH + 1);

  ld_entry_t        ld_in_c;
  ld_entry_t        ld_head_c;
  logic [CNT_W-1:0] ld_count;
  logic             ld_empty_c;
  logic             ld_cand_c;
  logic             contested_c;
  logic             grant_alu_c;
  logic             grant_ld_c;
  logic             rr;
  logic [XLEN-1:0]  ld_ext_c;
  logic [NREGS-1:0] pending_nxt_c;

  assign ld_in_c = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo, rdata: ld_rdata};

  wb_load_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (ld_valid && ld_ready),
    .din     (ld_in_c),
    .pop     (grant_ld_c),
    .dout_c  (ld_head_c),
    .count   (ld_count),
    .empty_c (ld_empty_c)
  );

  // Room is judged on registered occupancy only, so a full buffer stays
  // closed for one cycle even while it drains.
  assign ld_ready = (ld_count < CNT_W'(LD_DEPTH));

  // Round-robin arbiter: rr=0 prefers ALU, rr=1 prefers the load buffer.
  assign ld_cand_c   = !ld_empty_c;
  assign contested_c = alu_valid && ld_cand_c;
  assign grant_alu_c = alu_valid && (!ld_cand_c || !rr);
  assign grant_ld_c  = ld_cand_c && !grant_alu_c;
  assign alu_ready   = grant_alu_c;

  assign ld_ext_c = load_extend(ld_head_c.funct3, ld_head_c.addr_lo, ld_head_c.rdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (contested_c) begin
      rr <= grant_alu_c;
    end
  end

  // Write port: x0 results update data/rd but never raise the enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (grant_alu_c) begin
      rf_we    <= (alu_rd != '0);
      rf_rd    <= alu_rd;
      rf_wdata <= alu_result;
    end else if (grant_ld_c) begin
      rf_we    <= (ld_head_c.rd != '0);
      rf_rd    <= ld_head_c.rd;
      rf_wdata <= ld_ext_c;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Scoreboard: a same-edge issue to the committing register wins over the clear.
  always_comb begin
    pending_nxt_c = pending;
    if (rf_we)       pending_nxt_c[rf_rd]    = 1'b0;
    if (issue_valid) pending_nxt_c[issue_rd] = 1'b1;
    pending_nxt_c[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt_c;
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
module tb_wb_writeback_unit;

  localparam int unsigned LD_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  wb_writeback_unit #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: load buffer as a queue, scoreboard as a bit array.
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
  } mld_t;

  mld_t        mq[$];
  bit          m_rr;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;
  logic        obs_alu_ready;
  logic        obs_ld_ready;

  function automatic logic [31:0] ref_ext(input mld_t e);
    longint v;
    case (e.f3)
      3'b000, 3'b100: begin
        v = (longint'(e.data) >> (8 * int'(e.lo))) & 255;
        if (e.f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (longint'(e.data) >> (16 * int'(e.lo[1]))) & 65535;
        if (e.f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(e.data);
    endcase
    return v[31:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_pend = '0; m_we = 0; m_rd = '0; m_wdata = '0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_result = '0;
    ld_valid = 0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_rdata = '0;
    issue_valid = 0; issue_rd = '0;
  endtask

  // One clock with current inputs; checks handshakes then registered outputs.
  task automatic step();
    bit ld_ok, contested, alu_win, ld_win;
    logic [31:0] p;
    mld_t e;
    ld_ok     = mq.size() < LD_DEPTH;
    contested = alu_valid && (mq.size() > 0);
    alu_win   = contested ? !m_rr : bit'(alu_valid);
    ld_win    = (mq.size() > 0) && !alu_win;
    #1;
    obs_alu_ready = alu_ready;
    obs_ld_ready  = ld_ready;
    check("alu_ready", {31'b0, alu_ready}, {31'b0, alu_win});
    check("ld_ready", {31'b0, ld_ready}, {31'b0, ld_ok});
    p = m_pend;
    if (m_we) p[m_rd] = 1'b0;
    if (issue_valid) p[issue_rd] = 1'b1;
    p[0] = 1'b0;
    m_pend = p;
    if (alu_win) begin
      m_we = (alu_rd != 0); m_rd = alu_rd; m_wdata = alu_result;
    end else if (ld_win) begin
      e = mq.pop_front();
      m_we = (e.rd != 0); m_rd = e.rd; m_wdata = ref_ext(e);
    end else begin
      m_we = 0;
    end
    if (ld_valid && ld_ok) mq.push_back('{ld_rd, ld_funct3, ld_addr_lo, ld_rdata});
    if (contested) m_rr = alu_win;
    @(posedge clk); #1;
    check("rf_we", {31'b0, rf_we}, {31'b0, m_we});
    check("rf_rd", {27'b0, rf_rd}, {27'b0, m_rd});
    check("rf_wdata", rf_wdata, m_wdata);
    check("pending", pending, m_pend);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_rf_rd", {27'b0, rf_rd}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
  endtask

  typedef struct {
    bit          is_ld;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
    bit          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt [13];

  task automatic run_vec(input int idx, input vec_t v);
    idle_inputs();
    if (v.is_ld) begin
      ld_valid = 1; ld_rd = v.rd; ld_funct3 = v.f3; ld_addr_lo = v.lo; ld_rdata = v.data;
      step();
      idle_inputs();
      step();
    end else begin
      alu_valid = 1; alu_rd = v.rd; alu_result = v.data;
      step();
      idle_inputs();
    end
    check($sformatf("vec%0d_we", idx), {31'b0, rf_we}, {31'b0, v.exp_we});
    check($sformatf("vec%0d_rd", idx), {27'b0, rf_rd}, {27'b0, v.rd});
    check($sformatf("vec%0d_wdata", idx), rf_wdata, v.exp_wdata);
  endtask

  initial begin
    logic [6:0] pat;
    reset = 1;
    idle_inputs();
    model_reset();
    #12;
    @(negedge clk);
    do_reset();

    vt[0]  = '{0, 5'd5,  3'b000, 2'd0, 32'h0000_1234, 1, 32'h0000_1234};
    vt[1]  = '{1, 5'd6,  3'b000, 2'd3, 32'h80FF_7F01, 1, 32'hFFFF_FF80};
    vt[2]  = '{1, 5'd7,  3'b100, 2'd3, 32'h80FF_7F01, 1, 32'h0000_0080};
    vt[3]  = '{1, 5'd8,  3'b001, 2'd2, 32'h80FF_7F01, 1, 32'hFFFF_80FF};
    vt[4]  = '{1, 5'd9,  3'b101, 2'd0, 32'h80FF_7F01, 1, 32'h0000_7F01};
    vt[5]  = '{1, 5'd10, 3'b010, 2'd0, 32'h80FF_7F01, 1, 32'h80FF_7F01};
    vt[6]  = '{1, 5'd11, 3'b000, 2'd0, 32'h80FF_7F01, 1, 32'h0000_0001};
    vt[7]  = '{1, 5'd12, 3'b000, 2'd1, 32'h80FF_7F01, 1, 32'h0000_007F};
    vt[8]  = '{1, 5'd13, 3'b000, 2'd2, 32'h80FF_7F01, 1, 32'hFFFF_FFFF};
    vt[9]  = '{1, 5'd14, 3'b001, 2'd0, 32'h80FF_7F01, 1, 32'h0000_7F01};
    vt[10] = '{1, 5'd15, 3'b011, 2'd1, 32'h80FF_7F01, 1, 32'h80FF_7F01};
    vt[11] = '{0, 5'd0,  3'b000, 2'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vt[12] = '{1, 5'd16, 3'b110, 2'd2, 32'h1234_ABCD, 1, 32'h1234_ABCD};
    for (int i = 0; i < 13; i++) run_vec(i, vt[i]);
    check("x0_pending0", {31'b0, pending[0]}, 32'd0);

    // Scoreboard: set at issue, cleared after commit, set wins on collision.
    idle_inputs(); issue_valid = 1; issue_rd = 5'd5; step();
    check("sb_set5", pending, 32'h0000_0020);
    idle_inputs(); alu_valid = 1; alu_rd = 5'd5; alu_result = 32'h55; step();
    check("sb_commit_we", {31'b0, rf_we}, 32'd1);
    check("sb_hold5", pending, 32'h0000_0020);
    idle_inputs(); step();
    check("sb_clr5", pending, 32'h0);
    idle_inputs(); issue_valid = 1; issue_rd = 5'd7; step();
    idle_inputs(); alu_valid = 1; alu_rd = 5'd7; alu_result = 32'h77; step();
    idle_inputs(); issue_valid = 1; issue_rd = 5'd7; step();
    check("sb_setwins", pending, 32'h0000_0080);
    idle_inputs(); alu_valid = 1; alu_rd = 5'd7; alu_result = 32'h78; step();
    idle_inputs(); step();
    check("sb_clr7", pending, 32'h0);

    // Both sources always valid: grants alternate, FIFO full closes ld_ready.
    do_reset();
    pat = 7'b0101011;
    for (int i = 0; i < 7; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_result = 32'hA000_0000 + 32'(i);
      ld_valid = 1; ld_rd = 5'(10 + i); ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
      ld_rdata = 32'h0101_0101 * 32'(i + 1);
      step();
      check($sformatf("alt_alu_ready%0d", i), {31'b0, obs_alu_ready}, {31'b0, pat[i]});
      check($sformatf("alt_ld_ready%0d", i), {31'b0, obs_ld_ready}, {31'b0, pat[i]});
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Reset with two loads buffered and x2/x5 pending.
    do_reset();
    alu_valid = 1; alu_rd = 5'd0; alu_result = 32'h1;
    ld_valid = 1; ld_rd = 5'd3; ld_funct3 = 3'b010; ld_rdata = 32'h3333_3333;
    issue_valid = 1; issue_rd = 5'd2;
    step();
    ld_rd = 5'd4; ld_rdata = 32'h4444_4444; issue_rd = 5'd5;
    step();
    idle_inputs();
    check("rst_pre_pending", pending, 32'h0000_0024);
    check("rst_pre_ld_ready", {31'b0, ld_ready}, 32'd0);
    reset = 1;
    #1;
    check("rst_mid_pending", pending, 32'h0);
    check("rst_mid_ld_ready", {31'b0, ld_ready}, 32'd1);
    check("rst_mid_rf_we", {31'b0, rf_we}, 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    check("rst_post_rf_we", {31'b0, rf_we}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      alu_valid   = ($urandom_range(0, 99) < 55);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_result  = $urandom;
      ld_valid    = ($urandom_range(0, 99) < 60);
      ld_rd       = 5'($urandom_range(0, 31));
      ld_funct3   = 3'($urandom_range(0, 7));
      ld_addr_lo  = 2'($urandom_range(0, 3));
      ld_rdata    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd    = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
